// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// The auto-repeat option is compiled in with BTN_AUTOREPEAT_EN.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

  localparam int DBNC_W = 16;
  localparam int RPT_W  = 24;

  localparam logic [DBNC_W-1:0] DEF_DEBOUNCE_CYCLES = 16'd50000;
  localparam logic [RPT_W-1:0]  DEF_REPEAT_DELAY    = 24'd5000000;
  localparam logic [RPT_W-1:0]  DEF_REPEAT_PERIOD   = 24'd1000000;

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, debounce FSM and, with BTN_AUTOREPEAT_EN,
// a hold-to-repeat timer. accept is decoded one cycle before the top registers it.
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | button released and stable
// PRESS_CHK | input seen high, counting stable-high samples
// HELD      | press accepted, button held
// REL_CHK   | input seen low, counting stable-low samples
module btn_debounce
  import btn_pkg::*;
#(
  parameter logic [DBNC_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [RPT_W-1:0]  REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter logic [RPT_W-1:0]  REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic CLK,
  input  logic MR_N,
  input  logic raw,
  output logic accept,
  output logic held
);

  localparam logic [DBNC_W-1:0] CNT_TC = DEBOUNCE_CYCLES - 16'd1;

  logic              sync1, sync2;
  btn_state_e        state;
  logic [DBNC_W-1:0] cnt;
  logic              press_acc;

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (sync2) begin
          state <= PRESS_CHK;
          cnt   <= '0;
        end
        PRESS_CHK: begin
          if (!sync2)             state <= IDLE;
          else if (cnt == CNT_TC) state <= HELD;
          else                    cnt   <= cnt + 16'd1;
        end
        HELD: if (!sync2) begin
          state <= REL_CHK;
          cnt   <= '0;
        end
        REL_CHK: begin
          if (sync2)              state <= HELD;
          else if (cnt == CNT_TC) state <= IDLE;
          else                    cnt   <= cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign press_acc = (state == PRESS_CHK) && sync2 && (cnt == CNT_TC);
  assign held      = (state == HELD) || (state == REL_CHK);

`ifdef BTN_AUTOREPEAT_EN
  logic [RPT_W-1:0] rpt_tmr;
  logic             enter_held;
  logic             rpt_acc;

  // Entering HELD (fresh accept or a release bounce) restarts the initial delay.
  assign enter_held = press_acc || ((state == REL_CHK) && sync2);
  assign rpt_acc    = (state == HELD) && (rpt_tmr == '0);

  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      rpt_tmr <= '0;
    end else if (state == HELD) begin
      rpt_tmr <= rpt_acc ? (REPEAT_PERIOD - 24'd1) : (rpt_tmr - 24'd1);
    end else if (enter_held) begin
      rpt_tmr <= REPEAT_DELAY - 24'd1;
    end else begin
      rpt_tmr <= '0;
    end
  end

  assign accept = press_acc | rpt_acc;
`else
  logic unused_rpt;
  assign unused_rpt = ^{REPEAT_DELAY, REPEAT_PERIOD};
  assign accept     = press_acc;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Two debounced buttons feeding registered, mutually exclusive UP/DOWN pulses.
// Auto-repeat on a held button is compiled in with BTN_AUTOREPEAT_EN.
module button_conditioner
  import btn_pkg::*;
#(
  parameter logic [DBNC_W-1:0] DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [RPT_W-1:0]  REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter logic [RPT_W-1:0]  REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic CLK,
  input  logic MR_N,
  input  logic BTN_UP_RAW,
  input  logic BTN_DOWN_RAW,
  output logic UP,
  output logic DOWN,
  output logic UP_HELD,
  output logic DOWN_HELD
);

  logic acc_up, acc_dn;
  logic held_up, held_dn;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dbnc_up (
    .CLK   (CLK),
    .MR_N  (MR_N),
    .raw   (BTN_UP_RAW),
    .accept(acc_up),
    .held  (held_up)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) u_dbnc_dn (
    .CLK   (CLK),
    .MR_N  (MR_N),
    .raw   (BTN_DOWN_RAW),
    .accept(acc_dn),
    .held  (held_dn)
  );

  // Coincident accepts cancel; the counter never sees both.
  always_ff @(posedge CLK or negedge MR_N) begin
    if (!MR_N) begin
      UP   <= 1'b0;
      DOWN <= 1'b0;
    end else begin
      UP   <= acc_up & ~acc_dn;
      DOWN <= acc_dn & ~acc_up;
    end
  end

  assign UP_HELD   = held_up;
  assign DOWN_HELD = held_dn;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing input,
// each edge compared against a run-length model of the debounced buttons.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic CLK = 1'b0;
  logic MR_N, BTN_UP_RAW, BTN_DOWN_RAW;
  logic UP, DOWN, UP_HELD, DOWN_HELD;

  button_conditioner #(
    .DEBOUNCE_CYCLES(16'd4),
    .REPEAT_DELAY   (24'd20),
    .REPEAT_PERIOD  (24'd8)
  ) dut (
    .CLK         (CLK),
    .MR_N        (MR_N),
    .BTN_UP_RAW  (BTN_UP_RAW),
    .BTN_DOWN_RAW(BTN_DOWN_RAW),
    .UP          (UP),
    .DOWN        (DOWN),
    .UP_HELD     (UP_HELD),
    .DOWN_HELD   (DOWN_HELD)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_fail = 0;
  int k = 0;
  int n_up, n_dn, first_up, first_dn, k0;

  // model: raw delayed by the synchroniser, debounced level, disagreeing-run length,
  // edge of last entry into the held-and-stable condition
  logic rd1 [2];
  logic rd2 [2];
  logic lvl [2];
  logic hst [2];
  logic acc [2];
  int   dis [2];
  int   ent [2];
  logic e_up, e_dn;
  logic tgt [2];

  task automatic check(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %0b expected %0b", tag, k, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      rd1[b] = 1'b0; rd2[b] = 1'b0; lvl[b] = 1'b0; hst[b] = 1'b0;
      acc[b] = 1'b0; dis[b] = 0;    ent[b] = 0;
    end
    e_up = 1'b0;
    e_dn = 1'b0;
  endtask

  task automatic model_edge(input logic u, input logic d);
    logic raw [2];
    logic seen;
    raw[0] = u;
    raw[1] = d;
    for (int b = 0; b < 2; b++) begin
      seen   = rd2[b];
      rd2[b] = rd1[b];
      rd1[b] = raw[b];
      acc[b] = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      if (hst[b] && (k - ent[b]) >= RD && ((k - ent[b] - RD) % RP) == 0) acc[b] = 1'b1;
`endif
      if (seen !== lvl[b]) begin
        dis[b]++;
        if (dis[b] == D + 1) begin
          lvl[b] = seen;
          dis[b] = 0;
          if (seen) begin
            acc[b] = 1'b1;
            ent[b] = k;
          end
        end
      end else begin
        if (lvl[b] && dis[b] > 0) ent[b] = k;
        dis[b] = 0;
      end
      hst[b] = lvl[b] && (dis[b] == 0);
    end
    e_up = acc[0] & ~acc[1];
    e_dn = acc[1] & ~acc[0];
  endtask

  task automatic step(input logic u, input logic d);
    BTN_UP_RAW   = u;
    BTN_DOWN_RAW = d;
    @(posedge CLK);
    k++;
    model_edge(u, d);
    #1;
    check("up_pulse",   UP,        e_up);
    check("down_pulse", DOWN,      e_dn);
    check("up_held",    UP_HELD,   lvl[0]);
    check("down_held",  DOWN_HELD, lvl[1]);
    if (UP === 1'b1) begin
      if (n_up == 0) first_up = k;
      n_up++;
    end
    if (DOWN === 1'b1) begin
      if (n_dn == 0) first_dn = k;
      n_dn++;
    end
  endtask

  task automatic do_reset(input int cyc, input bit rnd, input logic u, input logic d);
    MR_N = 1'b0;
    model_reset();
    #1;
    check("rst_async_up",   UP,        1'b0);
    check("rst_async_down", DOWN,      1'b0);
    check("rst_async_uph",  UP_HELD,   1'b0);
    check("rst_async_dnh",  DOWN_HELD, 1'b0);
    for (int i = 0; i < cyc; i++) begin
      BTN_UP_RAW   = rnd ? 1'($urandom_range(0, 1)) : u;
      BTN_DOWN_RAW = rnd ? 1'($urandom_range(0, 1)) : d;
      @(posedge CLK);
      #1;
      check("rst_up",   UP,        1'b0);
      check("rst_down", DOWN,      1'b0);
      check("rst_uph",  UP_HELD,   1'b0);
      check("rst_dnh",  DOWN_HELD, 1'b0);
    end
    BTN_UP_RAW   = u;
    BTN_DOWN_RAW = d;
    MR_N = 1'b1;
  endtask

  task automatic clear_counts();
    n_up = 0; n_dn = 0; first_up = -1; first_dn = -1;
  endtask

  initial begin
    MR_N = 1'b0;
    BTN_UP_RAW = 1'b0;
    BTN_DOWN_RAW = 1'b0;
    model_reset();
    clear_counts();
    #2;

    do_reset(6, 1'b1, 1'b0, 1'b0);
    repeat (8) step(1'b0, 1'b0);
    check_int("idle_after_reset_pulses", n_up + n_dn, 0);

    // clean press held for 30 edges
    clear_counts();
    k0 = k + 1;
    repeat (30) step(1'b1, 1'b0);
    check_int("clean_latency", first_up - k0, 6);
`ifdef BTN_AUTOREPEAT_EN
    check_int("clean_count", n_up, 2);
`else
    check_int("clean_count", n_up, 1);
`endif
    check_int("clean_no_down", n_dn, 0);
    repeat (10) step(1'b0, 1'b0);

    // bouncing down press
    clear_counts();
    step(1'b0, 1'b1); step(1'b0, 1'b0); step(1'b0, 1'b1); step(1'b0, 1'b0);
    k0 = k + 1;
    repeat (12) step(1'b0, 1'b1);
    check_int("bounce_count", n_dn, 1);
    check_int("bounce_latency", first_dn - k0, 6);
    repeat (10) step(1'b0, 1'b0);

    // 3-cycle glitch is too short
    clear_counts();
    repeat (3) step(1'b1, 1'b0);
    repeat (10) step(1'b0, 1'b0);
    check_int("glitch_count", n_up, 0);

    // simultaneous press
    clear_counts();
    repeat (12) step(1'b1, 1'b1);
    check_int("simul_up", n_up, 0);
    check_int("simul_down", n_dn, 0);
    check("simul_uph", UP_HELD, 1'b1);
    check("simul_dnh", DOWN_HELD, 1'b1);
    repeat (10) step(1'b0, 1'b0);

    // staggered by 2 cycles
    clear_counts();
    repeat (2) step(1'b1, 1'b0);
    repeat (12) step(1'b1, 1'b1);
    check_int("stagger_up", n_up, 1);
    check_int("stagger_down", n_dn, 1);
    check_int("stagger_gap", first_dn - first_up, 2);
    repeat (10) step(1'b0, 1'b0);

    // reset during PRESS_CHK, button still held afterwards
    clear_counts();
    repeat (4) step(1'b1, 1'b0);
    do_reset(3, 1'b0, 1'b1, 1'b0);
    k0 = k + 1;
    repeat (12) step(1'b1, 1'b0);
    check_int("midrst_count", n_up, 1);
    check_int("midrst_latency", first_up - k0, 6);
    repeat (10) step(1'b0, 1'b0);

    // long hold
    clear_counts();
    k0 = k + 1;
    repeat (60) step(1'b1, 1'b0);
`ifdef BTN_AUTOREPEAT_EN
    check_int("hold60_count", n_up, 6);
`else
    check_int("hold60_count", n_up, 1);
`endif
    check_int("hold60_first", first_up - k0, 6);
    repeat (10) step(1'b0, 1'b0);

    // random bouncing buttons with occasional reset
    tgt[0] = 1'b0;
    tgt[1] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 2; b++)
        if ($urandom_range(0, 39) == 0) tgt[b] = ~tgt[b];
      if ($urandom_range(0, 999) == 0) do_reset(2, 1'b1, tgt[0], tgt[1]);
      step(tgt[0] ^ ($urandom_range(0, 7) == 0), tgt[1] ^ ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for the 3-bit saturating up/down counter. Takes the two raw, asynchronous, bouncing push-button inputs, synchronises and debounces them, and emits clean single-cycle UP/DOWN increment/decrement pulses in the counter's clock domain. If both buttons are accepted on the same cycle, neither pulse is issued, so the counter never sees UP and DOWN together.

## Interface
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable synchronised samples required to accept a press or release; legal range 2..65535.
- REPEAT_DELAY, 24'd5000000: hold time, in cycles, from accepted press to first auto-repeat pulse. Used only with auto-repeat compiled in.
- REPEAT_PERIOD, 24'd1000000: cycles between later auto-repeat pulses. Used only with auto-repeat compiled in.
- CLK  input  1  system clock; all logic is on the rising edge.
- MR_N  input  1  master reset, asynchronous, active-low.
- BTN_UP_RAW  input  1  raw up button, active-high, asynchronous, bouncing.
- BTN_DOWN_RAW  input  1  raw down button, active-high, asynchronous, bouncing.
- UP  output  1  one-cycle increment pulse to the counter.
- DOWN  output  1  one-cycle decrement pulse to the counter.
- UP_HELD  output  1  debounced level of the up button.
- DOWN_HELD  output  1  debounced level of the down button.

## Operation
- Per button: 2-flop synchroniser, then a debounce FSM with a 16-bit stability counter.
- FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
  - IDLE to PRESS_CHK when the synchronised input is 1. The counter clears.
  - PRESS_CHK: the counter increments each cycle the input is 1.
    - Input 0 returns the FSM to IDLE.
    - When the counter reaches DEBOUNCE_CYCLES-1 with input 1, the FSM goes to HELD and a raw accept pulse is raised for 1 cycle.
  - HELD to REL_CHK when the input is 0. The counter clears.
  - REL_CHK mirrors PRESS_CHK on input 0.
    - On success the FSM goes to IDLE, with no pulse.
    - Input 1 returns the FSM to HELD.
- UP_HELD and DOWN_HELD are 1 in states HELD and REL_CHK.
- Arbitration: UP = acc_up & ~acc_dn and DOWN = acc_dn & ~acc_up. A coincident accept is dropped and not queued.
- Each press gives exactly one pulse, regardless of bounce count or hold length, unless auto-repeat is compiled in.
- Reset mid-operation (MR_N low):
  - Synchronisers, FSMs and counters clear immediately.
  - UP, DOWN, UP_HELD and DOWN_HELD go to 0 asynchronously.
  - A button still held when MR_N rises is accepted as a fresh press after full debounce.

## Timing
- Reset values: every output is 0, both FSMs are in IDLE, all counters are 0.
- Latency: the raw input is first sampled 1 at edge 0. With a stable input, UP or DOWN is high during the cycle after edge DEBOUNCE_CYCLES+2.
- The pulse width is exactly 1 CLK cycle and is registered with no combinational path from any input.
- Release: HELD drops DEBOUNCE_CYCLES+2 edges after a stable release.
- Counters never wrap. They are compared against parameters only inside PRESS_CHK and REL_CHK.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - Each FSM gets a 24-bit repeat timer in HELD.
  - The timer issues an extra accept REPEAT_DELAY cycles after the initial pulse, then one every REPEAT_PERIOD cycles while in HELD.
  - The timer clears on leaving HELD. A REL_CHK bounce back to HELD restarts REPEAT_DELAY.
  - Arbitration applies to repeat pulses too.
- BTN_AUTOREPEAT_EN undefined: no repeat timer is generated, the REPEAT_* parameters are ignored, and each press gives exactly one pulse.

## Structure
- Package btn_pkg holds:
  - the FSM state enum (IDLE, PRESS_CHK, HELD, REL_CHK, 2 bits);
  - DBNC_W=16 and RPT_W=24;
  - the default parameter constants.
- Sub-module btn_debounce holds the synchroniser, FSM, counter and optional repeat timer for one button.
  - Ports: CLK, MR_N, raw, accept, held.
  - It is instantiated twice.
  - The top level does arbitration and output registers only.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY=20 and REPEAT_PERIOD=8 for simulation.
- Reset: drive MR_N=0 with both raw inputs toggling → all outputs 0. Release MR_N with inputs 0 → outputs stay 0.
- Clean press: BTN_UP_RAW rises and stays high → UP high for exactly one cycle, 6 edges after the first sample. UP_HELD stays 1. DOWN stays 0.
- Bounce: BTN_DOWN_RAW toggles 1,0,1,0 on single cycles, then holds 1 → exactly one DOWN pulse, counted from the last rising sample. A 3-cycle glitch alone gives no pulse.
- Simultaneous: both raw inputs rise on the same edge → no UP and no DOWN pulse, and UP_HELD = DOWN_HELD = 1. Staggering the rises by 2 cycles → one UP, then one DOWN.
- Reset mid-debounce: MR_N low during PRESS_CHK → no pulse. With the button still held after MR_N rises, UP fires 6 edges later.
- With BTN_AUTOREPEAT_EN, holding up for 60 cycles → an initial UP, then UP at +20, +28, +36, …. Without the macro → a single UP.
